// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Definitions shared by the I2C target and the I2C master controller:
// protocol FSM state encoding, bit-counter width, R/W bit position and
// ACK/NACK bus levels.
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_DATA,
        ST_RX_ACK,
        ST_TX_DATA,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    // Bit counter runs 7 down to 0 within each byte.
    localparam int BIT_CNT_W = 3;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
    localparam bit_cnt_t BIT_MSB = bit_cnt_t'(7);

    // Position of the R/W flag in the address byte and its read value.
    localparam int   RW_BIT  = 0;
    localparam logic RW_READ = 1'b1;

    // SDA level in the ninth bit slot.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// -----------------------------------------------------------------------------
// i2c_target_if
// Bundles the I2C pad signals and the host-side byte interface of the target.
//   I2C_SCL      bus clock from the pad
//   i2c_sda_in   SDA as read from the pad
//   i2c_sda_out  SDA output value (always 0, open-drain)
//   i2c_sda_oe   1 = pull SDA low, 0 = release
//   rx_data      last byte written by the bus master
//   rx_valid     one-cycle strobe, rx_data updated
//   rx_ready     host can accept a byte
//   tx_data      next byte to return on a read
//   tx_req       one-cycle strobe, host must present the next tx_data
//   busy         target addressed, between address match and STOP/NACK
// slave modport: the target itself. master modport: pads and host around it.
// -----------------------------------------------------------------------------
interface i2c_target_if;

    logic       I2C_SCL;
    logic       i2c_sda_in;
    logic       i2c_sda_out;
    logic       i2c_sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    modport slave (
        input  I2C_SCL, i2c_sda_in, rx_ready, tx_data,
        output i2c_sda_out, i2c_sda_oe, rx_data, rx_valid, tx_req, busy
    );

    modport master (
        output I2C_SCL, i2c_sda_in, rx_ready, tx_data,
        input  i2c_sda_out, i2c_sda_oe, rx_data, rx_valid, tx_req, busy
    );

endinterface

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Synchronises asynchronous SCL/SDA into the clk domain and derives bus
// events. Each line passes SYNC_STAGES flops plus one history flop; events
// are registered, so a pin change shows up as an event SYNC_STAGES+1 cycles
// later.
//   clk, rst   system clock, synchronous active-high reset
//   scl_in     raw SCL
//   sda_in     raw SDA
//   scl_rise   one-cycle pulse on SCL 0->1
//   scl_fall   one-cycle pulse on SCL 1->0
//   start      one-cycle pulse on SDA 1->0 while SCL high
//   stop       one-cycle pulse on SDA 0->1 while SCL high
//   sda        synchronised SDA level, aligned with the event pulses
// -----------------------------------------------------------------------------
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // NOTE: every flop in a clocked block uses <= so all of them sample the
    // pre-edge values; a blocking = here would collapse the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            // An idle bus sits high; resetting to 1 avoids phantom edges.
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda      <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            scl_rise <=  scl_s & ~scl_d;
            scl_fall <= ~scl_s &  scl_d;
            // SCL must be high on both samples so an SDA change that races
            // an SCL edge is not mistaken for START/STOP.
            start    <= scl_s & scl_d & ~sda_s &  sda_d;
            stop     <= scl_s & scl_d &  sda_s & ~sda_d;
            sda      <= sda_s;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
// I2C target responder. Matches a fixed 7-bit address, acknowledges it, then
// either hands received bytes to the host (rx_data/rx_valid, gated by
// rx_ready) or shifts out host-supplied bytes (tx_req/tx_data). SDA is driven
// open-drain: i2c_sda_out is tied low and i2c_sda_oe pulls the line.
//   CLK_100MHz  system clock (only clock)
//   rst         synchronous active-high reset
//   bus         i2c_target_if.slave: pad and host signals
// Parameters: ADDR (target address), SYNC_STAGES (input synchroniser depth).
// -----------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          CLK_100MHz,
    input  logic          rst,
    i2c_target_if.slave   bus
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk      (CLK_100MHz),
        .rst      (rst),
        .scl_in   (bus.I2C_SCL),
        .sda_in   (bus.i2c_sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda)
    );

    i2c_state_t state;
    bit_cnt_t   bit_cnt;
    logic [7:0] shift;
    logic       rw;
    logic       tx_load;   // next TX_DATA scl_fall starts a new byte
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    assign bus.i2c_sda_out = 1'b0;
    assign bus.i2c_sda_oe  = sda_oe;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.tx_req      = tx_req;
    assign bus.busy        = busy;

    always_ff @(posedge CLK_100MHz) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= BIT_MSB;
            shift    <= 8'h00;
            rw       <= 1'b0;
            tx_load  <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;

            // Bus conditions override any bit event seen in the same cycle.
            if (stop) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                state   <= ST_ADDR;
                bit_cnt <= BIT_MSB;
                sda_oe  <= 1'b0;
                tx_load <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda};
                            if (bit_cnt == '0) begin
                                // shift[6:0] holds the address, sda is R/W.
                                if (shift[6:0] == ADDR) begin
                                    state <= ST_ADDR_ACK;
                                    rw    <= sda;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end

                    // First fall opens the ACK slot (and asks the host for
                    // the first read byte so it has a whole bit period);
                    // second fall closes it and starts the data phase.
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                                tx_req <= (rw == RW_READ);
                            end else if (rw == RW_READ) begin
                                shift   <= bus.tx_data;
                                sda_oe  <= ~bus.tx_data[7];
                                bit_cnt <= BIT_MSB;
                                state   <= ST_TX_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= BIT_MSB;
                                state   <= ST_RX_DATA;
                            end
                        end
                    end

                    ST_RX_DATA: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda};
                            if (bit_cnt == '0) begin
                                if (bus.rx_ready) begin
                                    rx_data  <= {shift[6:0], sda};
                                    rx_valid <= 1'b1;
                                    state    <= ST_RX_ACK;
                                end else begin
                                    // Leave SDA released: the master sees NACK.
                                    state <= ST_WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end

                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= BIT_MSB;
                                state   <= ST_RX_DATA;
                            end
                        end
                    end

                    // bit_cnt names the bit currently on the bus; each fall
                    // moves to the next one, and the fall after bit 0 releases
                    // SDA for the master's ACK.
                    ST_TX_DATA: begin
                        if (scl_fall) begin
                            if (tx_load) begin
                                shift   <= bus.tx_data;
                                sda_oe  <= ~bus.tx_data[7];
                                bit_cnt <= BIT_MSB;
                                tx_load <= 1'b0;
                            end else if (bit_cnt == '0) begin
                                sda_oe <= 1'b0;
                                state  <= ST_TX_ACK;
                            end else begin
                                sda_oe  <= ~shift[bit_cnt - 1'b1];
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (sda == ACK) begin
                                tx_req  <= 1'b1;
                                tx_load <= 1'b1;
                                bit_cnt <= BIT_MSB;
                                state   <= ST_TX_DATA;
                            end else begin
                                state <= ST_WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end
                    end

                    ST_IDLE, ST_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end

                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_target
// Bench for i2c_target. The bench plays the bus master (bit-banged SCL/SDA
// with a wired-AND SDA) and the host (answers tx_req from a byte table,
// records every rx_valid byte). Expected values come from a transaction-level
// model of the protocol: which slots the target must ACK, which bytes must
// reach the host and which bytes must appear on a read.
// -----------------------------------------------------------------------------
module tb_i2c_target;
    import i2c_pkg::*;

    localparam logic [6:0] TGT = 7'h42;

    logic clk;
    logic rst;
    logic m_low;           // bench master pulling SDA low
    wire  sda_bus;

    int checks = 0;
    int passed = 0;

    // Host-side observation, written only by the monitor process.
    logic [7:0] rx_seen[$];
    int         tx_req_cnt = 0;
    logic [7:0] host_bytes[64];

    i2c_target_if bus ();

    assign sda_bus        = ~(m_low | bus.i2c_sda_oe);
    assign bus.i2c_sda_in = sda_bus;

    i2c_target #(
        .ADDR        (TGT),
        .SYNC_STAGES (2)
    ) dut (
        .CLK_100MHz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host model: answers tx_req from host_bytes and logs received bytes.
    initial begin
        bus.tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.rx_valid) rx_seen.push_back(bus.rx_data);
            if (bus.tx_req) begin
                bus.tx_data = host_bytes[tx_req_cnt % 64];
                tx_req_cnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit slot; entered and left with SCL low. drive=1 releases SDA.
    task automatic bit_xfer(input logic drive, output logic seen);
        cyc(4);
        m_low = ~drive;
        cyc(12);
        bus.I2C_SCL = 1'b1;
        cyc(8);
        seen = sda_bus;
        cyc(8);
        bus.I2C_SCL = 1'b0;
    endtask

    // START or repeated START; leaves SCL low.
    task automatic i2c_start();
        if (bus.I2C_SCL == 1'b0) begin
            cyc(8);
            m_low = 1'b0;
            cyc(8);
            bus.I2C_SCL = 1'b1;
            cyc(8);
        end
        m_low = 1'b1;
        cyc(8);
        bus.I2C_SCL = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(4);
        m_low = 1'b1;
        cyc(8);
        bus.I2C_SCL = 1'b1;
        cyc(8);
        m_low = 1'b0;
        cyc(16);
    endtask

    // Sends a byte; ack_level is the bus level seen in the ninth slot.
    task automatic write_byte(input logic [7:0] b, output logic ack_level);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack_level);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nack, s);
    endtask

    task automatic test_reset();
        checks++; if (bus.i2c_sda_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.i2c_sda_oe); else passed++;
        checks++; if (bus.i2c_sda_out !== 1'b0) $display("FAIL reset_out: got %b want 0", bus.i2c_sda_out); else passed++;
        checks++; if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); else passed++;
        checks++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); else passed++;
        checks++; if (bus.tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b want 0", bus.tx_req); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_write();
        logic [7:0] data[$];
        logic       a;
        int         rx0;
        data = '{8'hA5, 8'h3C};
        data.push_back(8'($urandom));
        rx0 = rx_seen.size();
        bus.rx_ready = 1'b1;
        i2c_start();
        write_byte({TGT, 1'b0}, a);
        checks++; if (a !== ACK) $display("FAIL wr_addr_ack: got %b want %b", a, ACK); else passed++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", bus.busy); else passed++;
        foreach (data[i]) begin
            write_byte(data[i], a);
            checks++; if (a !== ACK) $display("FAIL wr_data_ack%0d: got %b want %b", i, a, ACK); else passed++;
        end
        i2c_stop();
        checks++; if (bus.busy !== 1'b0) $display("FAIL wr_busy_stop: got %b want 0", bus.busy); else passed++;
        checks++; if (rx_seen.size() - rx0 !== data.size()) $display("FAIL wr_rx_count: got %0d want %0d", rx_seen.size() - rx0, data.size()); else passed++;
        foreach (data[i]) begin
            if (rx0 + i < rx_seen.size()) begin
                checks++; if (rx_seen[rx0 + i] !== data[i]) $display("FAIL wr_rx_byte%0d: got %h want %h", i, rx_seen[rx0 + i], data[i]); else passed++;
            end
        end
        checks++; if (bus.rx_data !== data[data.size() - 1]) $display("FAIL wr_rx_hold: got %h want %h", bus.rx_data, data[data.size() - 1]); else passed++;
    endtask

    task automatic test_addr_mismatch();
        logic [6:0] addrs[$];
        logic       a;
        int         rx0;
        int         oe_hits;
        addrs = '{7'h43, 7'h00};
        addrs.push_back(7'($urandom_range(0, 63)));   // never equals 0x42
        foreach (addrs[k]) begin
            rx0 = rx_seen.size();
            oe_hits = 0;
            i2c_start();
            write_byte({addrs[k], 1'b0}, a);
            checks++; if (a !== NACK) $display("FAIL mis_ack_%h: got %b want %b", addrs[k], a, NACK); else passed++;
            checks++; if (bus.busy !== 1'b0) $display("FAIL mis_busy_%h: got %b want 0", addrs[k], bus.busy); else passed++;
            for (int i = 0; i < 40; i++) begin
                cyc(1);
                if (bus.i2c_sda_oe) oe_hits++;
            end
            write_byte(8'($urandom), a);
            checks++; if (a !== NACK) $display("FAIL mis_data_ack_%h: got %b want %b", addrs[k], a, NACK); else passed++;
            i2c_stop();
            checks++; if (oe_hits !== 0 || rx_seen.size() !== rx0) $display("FAIL mis_quiet_%h: got oe_hits=%0d rx=%0d want 0 0", addrs[k], oe_hits, rx_seen.size() - rx0); else passed++;
        end
    endtask

    task automatic test_read();
        logic [7:0] d1, d2;
        logic       a;
        int         t0;
        t0 = tx_req_cnt;
        host_bytes[t0 % 64]       = 8'h81;
        host_bytes[(t0 + 1) % 64] = 8'h7E;
        i2c_start();
        write_byte({TGT, RW_READ}, a);
        checks++; if (a !== ACK) $display("FAIL rd_addr_ack: got %b want %b", a, ACK); else passed++;
        read_byte(ACK, d1);
        read_byte(NACK, d2);
        checks++; if (d1 !== 8'h81) $display("FAIL rd_byte1: got %h want 81", d1); else passed++;
        checks++; if (d2 !== 8'h7E) $display("FAIL rd_byte2: got %h want 7e", d2); else passed++;
        cyc(8);
        checks++; if (bus.i2c_sda_oe !== 1'b0) $display("FAIL rd_release: got %b want 0", bus.i2c_sda_oe); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rd_busy_nack: got %b want 0", bus.busy); else passed++;
        i2c_stop();
        checks++; if (tx_req_cnt - t0 !== 2) $display("FAIL rd_tx_req_count: got %0d want 2", tx_req_cnt - t0); else passed++;
    endtask

    task automatic test_rx_nack();
        logic a;
        int   rx0;
        rx0 = rx_seen.size();
        bus.rx_ready = 1'b0;
        i2c_start();
        write_byte({TGT, 1'b0}, a);
        checks++; if (a !== ACK) $display("FAIL nk_addr_ack: got %b want %b", a, ACK); else passed++;
        write_byte(8'h55, a);
        checks++; if (a !== NACK) $display("FAIL nk_data: got %b want %b", a, NACK); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL nk_busy: got %b want 0", bus.busy); else passed++;
        bus.rx_ready = 1'b1;
        write_byte(8'h0F, a);
        checks++; if (a !== NACK) $display("FAIL nk_wait_stop: got %b want %b", a, NACK); else passed++;
        i2c_stop();
        checks++; if (rx_seen.size() !== rx0) $display("FAIL nk_no_rx: got %0d want 0", rx_seen.size() - rx0); else passed++;
    endtask

    task automatic test_repeated_start();
        logic [7:0] hb, d;
        logic       a;
        int         t0;
        int         rx0;
        t0  = tx_req_cnt;
        rx0 = rx_seen.size();
        hb  = 8'($urandom);
        host_bytes[t0 % 64] = hb;
        bus.rx_ready = 1'b1;
        i2c_start();
        write_byte({TGT, 1'b0}, a);
        checks++; if (a !== ACK) $display("FAIL rs_addr_w: got %b want %b", a, ACK); else passed++;
        write_byte(8'h10, a);
        checks++; if (a !== ACK) $display("FAIL rs_data: got %b want %b", a, ACK); else passed++;
        i2c_start();
        write_byte({TGT, RW_READ}, a);
        checks++; if (a !== ACK) $display("FAIL rs_addr_r: got %b want %b", a, ACK); else passed++;
        read_byte(NACK, d);
        checks++; if (d !== hb) $display("FAIL rs_read: got %h want %h", d, hb); else passed++;
        i2c_stop();
        checks++; if (rx_seen.size() - rx0 !== 1 || bus.rx_data !== 8'h10) $display("FAIL rs_rx: got n=%0d data=%h want n=1 data=10", rx_seen.size() - rx0, bus.rx_data); else passed++;
        checks++; if (tx_req_cnt - t0 !== 1) $display("FAIL rs_tx_req: got %0d want 1", tx_req_cnt - t0); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] hb, wb;
        logic       a, s;
        hb = 8'hEF;                       // bit 4 is 0: target pulls SDA then
        host_bytes[tx_req_cnt % 64] = hb;
        i2c_start();
        write_byte({TGT, RW_READ}, a);
        checks++; if (a !== ACK) $display("FAIL rm_addr_ack: got %b want %b", a, ACK); else passed++;
        for (int i = 7; i > 4; i--) bit_xfer(1'b1, s);
        cyc(4);
        m_low = 1'b0;
        cyc(12);
        bus.I2C_SCL = 1'b1;
        cyc(6);
        checks++; if (bus.i2c_sda_oe !== ~hb[4]) $display("FAIL rm_driving: got %b want %b", bus.i2c_sda_oe, ~hb[4]); else passed++;
        rst = 1'b1;
        cyc(1);
        checks++; if (bus.i2c_sda_oe !== 1'b0) $display("FAIL rm_oe: got %b want 0", bus.i2c_sda_oe); else passed++;
        checks++; if (bus.busy !== 1'b0 || bus.rx_valid !== 1'b0 || bus.tx_req !== 1'b0) $display("FAIL rm_strobes: got busy=%b rx_valid=%b tx_req=%b want 0 0 0", bus.busy, bus.rx_valid, bus.tx_req); else passed++;
        checks++; if (bus.rx_data !== 8'h00) $display("FAIL rm_rx_data: got %h want 00", bus.rx_data); else passed++;
        cyc(3);
        rst = 1'b0;
        cyc(4);
        bus.I2C_SCL = 1'b0;
        cyc(8);
        i2c_stop();
        wb = 8'($urandom);
        i2c_start();
        write_byte({TGT, 1'b0}, a);
        checks++; if (a !== ACK) $display("FAIL rm_after_addr: got %b want %b", a, ACK); else passed++;
        write_byte(wb, a);
        checks++; if (a !== ACK) $display("FAIL rm_after_data: got %b want %b", a, ACK); else passed++;
        i2c_stop();
        checks++; if (bus.rx_data !== wb) $display("FAIL rm_after_rx: got %h want %h", bus.rx_data, wb); else passed++;
    endtask

    // Random transactions against a transaction-level protocol model.
    task automatic test_random();
        logic [6:0] addr;
        logic       rw, match, active, rdy, a, exp_a;
        logic [7:0] d, exp_d;
        logic [7:0] hb[3];
        logic [7:0] exp_rx[$];
        int         len, t0, rx0;
        for (int t = 0; t < 8; t++) begin
            addr = ($urandom_range(0, 1) == 1) ? TGT : 7'($urandom_range(0, 127));
            rw   = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 3);
            match = (addr == TGT);
            t0  = tx_req_cnt;
            rx0 = rx_seen.size();
            exp_rx.delete();
            for (int i = 0; i < 3; i++) begin
                hb[i] = 8'($urandom);
                host_bytes[(t0 + i) % 64] = hb[i];
            end
            i2c_start();
            write_byte({addr, rw}, a);
            exp_a = match ? ACK : NACK;
            checks++; if (a !== exp_a) $display("FAIL rnd%0d_addr_ack: got %b want %b (addr %h)", t, a, exp_a, addr); else passed++;
            checks++; if (bus.busy !== match) $display("FAIL rnd%0d_busy: got %b want %b", t, bus.busy, match); else passed++;
            if (rw == 1'b0) begin
                active = match;
                for (int i = 0; i < len; i++) begin
                    rdy = ($urandom_range(0, 3) != 0);
                    bus.rx_ready = rdy;
                    d = 8'($urandom);
                    write_byte(d, a);
                    exp_a = (active && rdy) ? ACK : NACK;
                    checks++; if (a !== exp_a) $display("FAIL rnd%0d_wr_ack%0d: got %b want %b", t, i, a, exp_a); else passed++;
                    if (active && rdy) exp_rx.push_back(d);
                    if (!rdy) active = 1'b0;
                end
            end else begin
                for (int i = 0; i < len; i++) begin
                    read_byte((i == len - 1) ? NACK : ACK, d);
                    exp_d = match ? hb[i] : 8'hFF;
                    checks++; if (d !== exp_d) $display("FAIL rnd%0d_rd%0d: got %h want %h", t, i, d, exp_d); else passed++;
                end
            end
            i2c_stop();
            bus.rx_ready = 1'b1;
            checks++; if (bus.busy !== 1'b0) $display("FAIL rnd%0d_busy_stop: got %b want 0", t, bus.busy); else passed++;
            checks++; if (tx_req_cnt - t0 !== ((match && rw) ? len : 0)) $display("FAIL rnd%0d_tx_req: got %0d want %0d", t, tx_req_cnt - t0, (match && rw) ? len : 0); else passed++;
            checks++; if (rx_seen.size() - rx0 !== exp_rx.size()) $display("FAIL rnd%0d_rx_count: got %0d want %0d", t, rx_seen.size() - rx0, exp_rx.size()); else passed++;
            foreach (exp_rx[i]) begin
                if (rx0 + i < rx_seen.size()) begin
                    checks++; if (rx_seen[rx0 + i] !== exp_rx[i]) $display("FAIL rnd%0d_rx%0d: got %h want %h", t, i, rx_seen[rx0 + i], exp_rx[i]); else passed++;
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        m_low        = 1'b0;
        bus.I2C_SCL  = 1'b1;
        bus.rx_ready = 1'b1;
        cyc(5);
        rst = 1'b0;
        cyc(5);
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_rx_nack();
        test_repeated_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder on the `CLK_100MHz` domain. It sits at the far end of the bus from the I2C master controller. It oversamples SCL/SDA, detects START/STOP, and matches a fixed 7-bit address. It then receives write bytes into a host-side strobe interface or shifts out host-supplied read bytes, driving SDA open-drain through the same out/oe tristate convention as the master.

## Interface
Parameters:
- `ADDR`, 7'h42, 7-bit target address matched against the first byte after START.
- `SYNC_STAGES`, 2, synchronizer depth on SCL and SDA inputs (≥2).

Ports:
- `CLK_100MHz`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `I2C_SCL`  in  1  bus clock (asynchronous).
- `i2c_sda_in`  in  1  bus data as read from the pad (asynchronous).
- `i2c_sda_out`  out  1  pad data; constant 0 (open-drain).
- `i2c_sda_oe`  out  1  1 = pull SDA low, 0 = high impedance.
- `rx_data`  out  8  last byte written by the master.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `rx_ready`  in  1  host can accept a byte; sampled at the 8th data bit.
- `tx_data`  in  8  next byte to return on a read.
- `tx_req`  out  1  one-cycle strobe: host must present the next `tx_data`.
- `busy`  out  1  target addressed, between matching address and STOP or NACK.

## Operation
- Front end: SCL and SDA pass through `SYNC_STAGES` flops plus one history flop. This yields `scl_rise`, `scl_fall`, `start` (SDA 1→0 while SCL high) and `stop` (SDA 0→1 while SCL high).
- START or repeated START in any state loads bit counter = 7 and enters ADDR. STOP in any state enters IDLE and releases SDA. Both take priority over bit events in the same cycle.
- Bits are MSB first, sampled on `scl_rise`. SDA drive changes only on `scl_fall`.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits. At bit 0, if [7:1]==`ADDR`, go to ADDR_ACK and latch R/W. Otherwise go to WAIT_STOP.
  - ADDR_ACK: pull SDA low for one bit period and assert `busy`. Next is TX_DATA with `tx_req` pulse (R/W=1) or RX_DATA (R/W=0).
  - RX_DATA: shift 8 bits. At bit 0, if `rx_ready`=1: update `rx_data`, pulse `rx_valid`, go to RX_ACK (ACK). If `rx_ready`=0: go to WAIT_STOP (NACK; SDA left released).
  - RX_ACK: pull SDA low for one bit period, then RX_DATA.
  - TX_DATA: on each `scl_fall`, drive `i2c_sda_oe` = ~shift[bit]; after 8 bits release SDA and go to TX_ACK.
  - TX_ACK: sample master ACK on `scl_rise`. SDA=0: pulse `tx_req`, reload counter, go to TX_DATA. SDA=1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released, `busy`=0; wait for START or STOP.
- The `tx_data` shift register loads on the `scl_fall` that begins the first bit of each read byte.
- Only `ADDR` is matched; general call (0x00) is ignored.
- Counter is 3 bits, 7 down to 0; no wrap beyond 0 within a byte.

## Timing
- Reset values: `i2c_sda_oe`=0, `i2c_sda_out`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, state IDLE. Reset asserted mid-transfer releases SDA on the next clock edge.
- Detection latency: pin change to internal event = `SYNC_STAGES`+1 cycles. SDA drive follows `scl_fall` detection by 1 cycle (4 cycles total at default).
- Bus requirement: SCL high and low phases ≥ 8 `CLK_100MHz` cycles. The master's 64-cycle divider satisfies this.
- `rx_valid` fires 1 cycle after the 8th data `scl_rise`. `rx_data` is stable until the next `rx_valid`.
- `tx_req` fires 1 cycle after the ACK `scl_rise`, and after the ADDR_ACK `scl_fall` for the first byte. `tx_data` must be valid within 2 cycles of `tx_req` and held until the next `scl_fall`.

## Structure
- Shared `i2c_pkg`: state encodings, bit-counter width, R/W bit position, ACK/NACK constants. The master controller uses the same package.
- Sub-module `i2c_line_sync`: synchronizers and edge/START/STOP detection, reusable by the master.

## Test plan
- Write 0x42 address + W, data 0xA5, 0x3C, STOP, `rx_ready`=1 -> ACK on every 9th bit; `rx_valid` ×2 with `rx_data` 0xA5 then 0x3C; `busy` drops at STOP.
- Address 0x43 + W -> SDA never driven; no `rx_valid`; `busy`=0; target stays in WAIT_STOP until STOP.
- Read 0x42 + R, host answers `tx_req` with 0x81 then 0x7E; master ACKs byte 1 and NACKs byte 2 -> SDA bits 1000_0001, 0111_1110; exactly 2 `tx_req` pulses; SDA released after NACK.
- Write byte 0x55 with `rx_ready`=0 -> NACK (SDA high at 9th bit); no `rx_valid`; WAIT_STOP.
- Repeated START after writing 0x10, then 0x42 + R -> no STOP needed; ADDR re-entered; ACK; `tx_req` pulses.
- `rst` asserted during bit 4 of a read byte -> `i2c_sda_oe`=0 next cycle; all outputs at reset values; a subsequent clean transaction completes.
